// File: rtl/pipelined_add_sub.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_add_sub
// Purpose  : Segmented carry-chain adder/subtractor with valid/ready flow
//            control. Each of S = N/SEG stages resolves one SEG-bit slice of
//            the carry chain and registers the carry into the next stage,
//            giving S cycles of latency and one operation per cycle.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            in_valid/ready  - operand handshake
//            in_a, in_b      - N-bit operands
//            in_cin          - carry-in (add mode only)
//            in_sub          - 0: a+b+cin, 1: a-b
//            out_valid/ready - result handshake
//            out_sum         - N-bit result
//            out_cout        - carry out of bit N-1 (1 = no borrow on sub)
//            out_ovf         - signed two's-complement overflow
// Revision : 1.0 - initial release
// ============================================================================
module pipelined_add_sub #(
    parameter int N   = 32,   // must be a positive multiple of SEG
    parameter int SEG = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_a,
    input  logic [N-1:0] in_b,
    input  logic         in_cin,
    input  logic         in_sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_sum,
    output logic         out_cout,
    output logic         out_ovf
);

    localparam int S = N / SEG;

    // Per-stage state. Operand registers keep full width; only the slices
    // still to be consumed (plus the MSBs needed for overflow) matter.
    logic         r_vld [S];
    logic [N-1:0] r_sum [S];
    logic [N-1:0] r_a   [S];
    logic [N-1:0] r_b   [S];
    logic         r_c   [S];

    // The whole pipeline freezes while the output beat is held back.
    logic w_stall;
    assign w_stall  = out_valid && !out_ready;
    assign in_ready = !w_stall;

    genvar k;
    generate
        for (k = 0; k < S; k++) begin : g_stage
            if (k == 0) begin : g_first
                logic [N-1:0] w_b_eff;
                logic         w_cin;
                logic [SEG:0] w_slice;
                logic [N-1:0] w_sum;

                // Subtract as a + ~b + 1: invert b here and force carry-in.
                always_comb begin
                    w_b_eff = in_sub ? ~in_b : in_b;
                    w_cin   = in_sub ? 1'b1 : in_cin;
                    w_slice = {1'b0, in_a[SEG-1:0]} + {1'b0, w_b_eff[SEG-1:0]}
                            + {{SEG{1'b0}}, w_cin};
                    w_sum          = '0;
                    w_sum[SEG-1:0] = w_slice[SEG-1:0];
                end

                always_ff @(posedge clk) begin
                    if (rst) begin
                        r_vld[0] <= 1'b0;
                        r_sum[0] <= '0;
                        r_a[0]   <= '0;
                        r_b[0]   <= '0;
                        r_c[0]   <= 1'b0;
                    end else if (!w_stall) begin
                        r_vld[0] <= in_valid;
                        // Data only moves with a valid beat, so the final
                        // stage keeps its last result across bubbles.
                        if (in_valid) begin
                            r_sum[0] <= w_sum;
                            r_a[0]   <= in_a;
                            r_b[0]   <= w_b_eff;
                            r_c[0]   <= w_slice[SEG];
                        end
                    end
                end
            end else begin : g_next
                logic [SEG:0] w_slice;
                logic [N-1:0] w_sum;

                always_comb begin
                    w_slice = {1'b0, r_a[k-1][k*SEG +: SEG]}
                            + {1'b0, r_b[k-1][k*SEG +: SEG]}
                            + {{SEG{1'b0}}, r_c[k-1]};
                    w_sum                = r_sum[k-1];
                    w_sum[k*SEG +: SEG]  = w_slice[SEG-1:0];
                end

                always_ff @(posedge clk) begin
                    if (rst) begin
                        r_vld[k] <= 1'b0;
                        r_sum[k] <= '0;
                        r_a[k]   <= '0;
                        r_b[k]   <= '0;
                        r_c[k]   <= 1'b0;
                    end else if (!w_stall) begin
                        r_vld[k] <= r_vld[k-1];
                        if (r_vld[k-1]) begin
                            r_sum[k] <= w_sum;
                            r_a[k]   <= r_a[k-1];
                            r_b[k]   <= r_b[k-1];
                            r_c[k]   <= w_slice[SEG];
                        end
                    end
                end
            end
        end
    endgenerate

    assign out_valid = r_vld[S-1];
    assign out_sum   = r_sum[S-1];
    assign out_cout  = r_c[S-1];
    // Overflow: operands of equal sign producing a result of the other sign.
    assign out_ovf   = (r_a[S-1][N-1] == r_b[S-1][N-1])
                    && (r_sum[S-1][N-1] != r_a[S-1][N-1]);

endmodule
`default_nettype wire

// File: tb/tb_pipelined_add_sub.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipelined_add_sub
// Purpose  : Self-checking bench for pipelined_add_sub: directed vector
//            table, randomised stream with backpressure, mid-stream reset and
//            single/three-stage configurations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipelined_add_sub;

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } res_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        sub;
        res_t        r;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        in_valid, in_ready, in_cin, in_sub;
    logic [31:0] in_a, in_b, out_sum;
    logic        out_valid, out_ready, out_cout, out_ovf;

    logic        iv8, ir8, ov8, co8, of8, or8;
    logic [7:0]  a8, b8, s8;
    logic        iv12, ir12, ov12, co12, of12, or12, sub12;
    logic [11:0] a12, b12, s12;

    int   checks = 0;
    int   errors = 0;
    res_t sb[$];
    res_t exp_cur;
    res_t r_pop;
    logic mon_en = 1'b0;
    logic p_stall = 1'b0;
    logic [31:0] p_sum;
    logic p_cout, p_ovf;
    vec_t tab[7];

    pipelined_add_sub #(.N(32), .SEG(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_cout(out_cout), .out_ovf(out_ovf));

    pipelined_add_sub #(.N(8), .SEG(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8),
        .in_a(a8), .in_b(b8), .in_cin(1'b0), .in_sub(1'b0),
        .out_valid(ov8), .out_ready(or8), .out_sum(s8),
        .out_cout(co8), .out_ovf(of8));

    pipelined_add_sub #(.N(12), .SEG(4)) dut12 (
        .clk(clk), .rst(rst), .in_valid(iv12), .in_ready(ir12),
        .in_a(a12), .in_b(b12), .in_cin(1'b0), .in_sub(sub12),
        .out_valid(ov12), .out_ready(or12), .out_sum(s12),
        .out_cout(co12), .out_ovf(of12));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic res_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic cin, input logic sub);
        logic [31:0] be;
        logic [32:0] t;
        res_t        r;
        be     = sub ? ~b : b;
        t      = {1'b0, a} + {1'b0, be} + {32'd0, (sub ? 1'b1 : cin)};
        r.sum  = t[31:0];
        r.cout = t[32];
        r.ovf  = (a[31] == be[31]) && (t[31] != a[31]);
        return r;
    endfunction

    // Scoreboard monitor, sampled on the falling edge away from updates.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("in_ready", in_ready, !(out_valid && !out_ready));
            if (p_stall) begin
                chk("stall_valid", out_valid, 1'b1);
                chk("stall_sum", out_sum, p_sum);
                chk("stall_cout", out_cout, p_cout);
                chk("stall_ovf", out_ovf, p_ovf);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got sum %0h expected no beat", out_sum);
                end else begin
                    r_pop = sb.pop_front();
                    chk("sum", out_sum, r_pop.sum);
                    chk("cout", out_cout, r_pop.cout);
                    chk("ovf", out_ovf, r_pop.ovf);
                end
            end
            if (in_valid && in_ready) sb.push_back(exp_cur);
            p_stall = out_valid && !out_ready && !rst;
            p_sum   = out_sum;
            p_cout  = out_cout;
            p_ovf   = out_ovf;
        end
    end

    // All driving tasks start and end just after a rising edge.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic cin,
                        input logic sub, input res_t e, input bit rnd);
        int n;
        bit acc;
        in_a = a; in_b = b; in_cin = cin; in_sub = sub;
        exp_cur  = e;
        in_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (rnd) out_ready = ($urandom_range(0, 2) != 0);
            n++;
        end while (!acc && n < 60);
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready 0 expected 1 within 60 cycles");
        end
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n, input bit rnd);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
            if (rnd) out_ready = ($urandom_range(0, 2) != 0);
        end
    endtask

    task automatic lat_test(input logic [31:0] a, input logic [31:0] b, input logic cin,
                            input logic sub, input res_t e);
        int n;
        out_ready = 1'b1;
        in_a = a; in_b = b; in_cin = cin; in_sub = sub;
        exp_cur  = e;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        n = 1;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("latency", n, 4);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int l8, l12;
        logic [31:0] ra, rb;
        logic rc, rs;

        tab[0] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, '{32'h0000_0000, 1'b1, 1'b0}};
        tab[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, '{32'h8000_0000, 1'b0, 1'b1}};
        tab[2] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, '{32'h0000_0000, 1'b1, 1'b1}};
        tab[3] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, '{32'hFFFF_FFFE, 1'b0, 1'b0}};
        tab[4] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, '{32'h7FFF_FFFF, 1'b1, 1'b1}};
        tab[5] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, '{32'h0000_0100, 1'b0, 1'b0}};
        tab[6] = '{32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0, '{32'hACF1_3568, 1'b0, 1'b0}};

        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0;
        out_ready = 1'b1;
        iv8 = 1'b0; a8 = '0; b8 = '0; or8 = 1'b1;
        iv12 = 1'b0; a12 = '0; b12 = '0; sub12 = 1'b0; or12 = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_sum", out_sum, 32'h0);
        chk("rst_out_cout", out_cout, 1'b0);
        chk("rst_out_ovf", out_ovf, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_valid8", ov8, 1'b0);
        chk("rst_valid12", ov12, 1'b0);
        @(posedge clk);
        #1 mon_en = 1'b1;

        // First-beat latency, then the directed table back-to-back.
        lat_test(tab[0].a, tab[0].b, tab[0].cin, tab[0].sub, tab[0].r);
        for (int i = 0; i < 7; i++)
            send(tab[i].a, tab[i].b, tab[i].cin, tab[i].sub, tab[i].r, 1'b0);
        idle(6, 1'b0);
        chk("table_drained", sb.size(), 0);

        // Random stream with input gaps and output backpressure.
        for (int i = 0; i < 16; i++) begin
            idle($urandom_range(0, 1), 1'b1);
            ra = $urandom(); rb = $urandom();
            rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
            send(ra, rb, rc, rs, model(ra, rb, rc, rs), 1'b1);
        end
        out_ready = 1'b1;
        idle(8, 1'b0);
        chk("stream_drained", sb.size(), 0);

        // Reset with three beats in flight.
        for (int i = 0; i < 3; i++)
            send(tab[i + 4].a, tab[i + 4].b, tab[i + 4].cin, tab[i + 4].sub, tab[i + 4].r, 1'b0);
        rst = 1'b1;
        sb.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_valid", out_valid, 1'b0);
        chk("midrst_sum", out_sum, 32'h0);
        chk("midrst_cout", out_cout, 1'b0);
        chk("midrst_ovf", out_ovf, 1'b0);
        chk("midrst_in_ready", in_ready, 1'b1);
        repeat (10) begin
            @(negedge clk);
            chk("midrst_no_stale", out_valid, 1'b0);
        end
        @(posedge clk);
        #1;
        lat_test(tab[3].a, tab[3].b, tab[3].cin, tab[3].sub, tab[3].r);
        idle(6, 1'b0);
        chk("postrst_drained", sb.size(), 0);

        // Single-stage and three-stage configurations.
        a8 = 8'hFF; b8 = 8'h01; iv8 = 1'b1;
        a12 = 12'h800; b12 = 12'h001; sub12 = 1'b1; iv12 = 1'b1;
        @(posedge clk);
        #1 iv8 = 1'b0; iv12 = 1'b0;
        l8 = 0; l12 = 0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (ov8 && l8 == 0) begin
                l8 = n;
                chk("n8_sum", s8, 8'h00);
                chk("n8_cout", co8, 1'b1);
                chk("n8_ovf", of8, 1'b0);
            end
            if (ov12 && l12 == 0) begin
                l12 = n;
                chk("n12_sum", s12, 12'h7FF);
                chk("n12_cout", co12, 1'b1);
                chk("n12_ovf", of12, 1'b1);
            end
        end
        chk("n8_latency", l8, 1);
        chk("n12_latency", l12, 3);

        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipelined_add_sub.md
# pipelined_add_sub

Parameterised, segmented carry-chain adder/subtractor with a valid/ready handshake. It is the registered successor to the combinational ripple-carry adder. Each pipeline stage resolves one SEG-bit slice of the carry chain and registers the carry into the next stage, so timing closes at wide N with a throughput of one operation per cycle. It sits between operand producers and result consumers that can apply backpressure, and it adds carry-in, subtract mode, signed overflow and stall handling.

## Interface
- N, default 32: operand/result width; N must be a positive multiple of SEG.
- SEG, default 8: bits resolved per stage; S = N/SEG stages (SEG = N gives a single stage).
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- in_a  input  N  operand A (unsigned/two's complement).
- in_b  input  N  operand B.
- in_cin  input  1  carry-in; used only when in_sub=0.
- in_sub  input  1  0: A+B+cin; 1: A-B (cin ignored).
- out_valid  output  1  result beat valid.
- out_ready  input  1  consumer accepts the result.
- out_sum  output  N  result.
- out_cout  output  1  carry out of bit N-1 (in subtract mode, 1 = no borrow).
- out_ovf  output  1  signed two's-complement overflow.

## Operation
- Subtract is computed as A + ~B + 1: stage 0 inverts B and forces carry-in to 1.
- Stage k (0..S-1) holds:
  - a valid bit;
  - the result bits [k*SEG+SEG-1:0] resolved so far;
  - the unconsumed upper slices of A and the effective B;
  - the carry out of slice k.
- Stage k adds slice k of A and effective B plus the carry from stage k-1 (stage 0 uses the initial carry).
- Final stage computes:
  - out_cout = carry out of bit N-1;
  - out_ovf = (a[N-1] == b_eff[N-1]) && (sum[N-1] != a[N-1]).
- All arithmetic is modulo 2^N. The carry is the only value carried between stages.
- stall = out_valid && !out_ready. in_ready = !stall, combinational from out_valid and out_ready.
- While stall=1:
  - every stage register, including valid bits, holds;
  - out_* stay stable;
  - in_valid is ignored and no beat is accepted.
- While stall=0, every stage advances one position. Stage 0 loads in_valid and the operands; when in_valid=0 a bubble (valid=0) enters.
- Bubbles are not compressed: the pipeline stalls as a whole.
- Data registers may be left non-gated on bubbles, but out_sum, out_cout and out_ovf must hold their last values whenever out_valid=0 after reset.
- Results leave in strict acceptance order, with no reordering or dropping.

## Timing
- Reset (rst=1 at a rising edge):
  - all valid bits clear;
  - out_valid=0, out_sum=0, out_cout=0, out_ovf=0;
  - in_ready=1 from the cycle after the reset edge.
- Reset overrides stall and in_valid.
- A beat is accepted on a rising edge where in_valid && in_ready.
- Latency is S cycles from the accept edge: out_valid is first seen after the S-th rising edge, counting the accept edge as edge 1.
- A result is transferred on an edge where out_valid && out_ready. With out_ready held at 1, throughput is 1 beat per cycle.
- When out_valid=0, stall=0 regardless of out_ready. The pipeline always drains toward the output.
- Simultaneous events on one edge:
  - accept plus transfer: both occur;
  - reset mid-stream: all in-flight beats are discarded and none appear afterward.
- With SEG=N (S=1), the result is registered one cycle after acceptance.

## Test plan
- Defaults, out_ready=1. Add 0xFFFFFFFF + 0x00000000, cin=1 -> sum 0x00000000, cout=1, ovf=0, out_valid exactly 4 cycles after accept.
- Add 0x7FFFFFFF + 0x00000001, cin=0 -> sum 0x80000000, cout=0, ovf=1. Add 0x80000000 + 0x80000000 -> sum 0x00000000, cout=1, ovf=1.
- Subtract 5 - 7 with cin=1 (must be ignored) -> sum 0xFFFFFFFE, cout=0, ovf=0. Subtract 0x80000000 - 1 -> sum 0x7FFFFFFF, cout=1, ovf=1.
- Stream 16 random beats back-to-back while out_ready follows a pseudo-random pattern and in_valid has gaps:
  - every result matches a reference model, in order, with no loss or duplication;
  - in_ready=0 exactly when out_valid && !out_ready;
  - outputs are stable throughout each stall.
- Accept 3 beats, then assert rst for 1 cycle -> out_valid=0 with all outputs 0. No stale beat emerges in the following 10 cycles, and a new beat after reset completes correctly.
- N=8, SEG=8 (S=1): 0xFF+0x01 -> 0x00, cout=1, 1-cycle latency. N=12, SEG=4: 0x800-0x001 -> 0x7FF, ovf=1, 3-cycle latency.
